// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, ALU code type, EX control
// bundle with its bubble value, and the ID/EX stage FSM encoding.
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef logic [3:0] alu_ctrl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Control bits for an empty EX slot; nothing downstream may commit it.
    localparam ctrl_t BUBBLE_CTRL = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0};

    typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a valid load in EX whose destination (non-zero)
// matches either source of a valid instruction in ID.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    logic rd_match;

    assign rd_match = (ex_rd == id_rs) | (ex_rd == id_rt);
    assign hazard   = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid & rd_match;

endmodule

// File: rtl/id_exe_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Define ID_EXE_STATS_EN to add the saturating stall_count output.
module id_exe_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_op1,
    input  logic [DATA_W-1:0] id_op2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              flush,
    output logic [REG_W-1:0]  ID_EXE_Rs,
    output logic [REG_W-1:0]  ID_EXE_Rt,
    output logic [REG_W-1:0]  ID_EXE_Rd,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_ctrl,
    output logic              stall
`ifdef ID_EXE_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    state_t    state, state_nxt;
    ctrl_t     ex_ctrl, id_ctrl;
    alu_ctrl_t alu_q;
    logic      hazard, load_bubble;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_valid    (ex_ctrl.valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ID_EXE_Rd),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard)
    );

    // Flush wins: the ID instruction dies anyway, so holding fetch is pointless.
    assign stall = hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
        case (state)
            RUN:     state_nxt = stall ? BUBBLE : RUN;
            BUBBLE:  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (flush) state_nxt = RUN;
    end

    always_comb begin
        load_bubble = stall | flush;
    end

    // An invalid ID slot enters EX as a bubble, so its controls are gated too.
    assign id_ctrl = '{valid:     id_valid,
                       reg_write: id_valid & id_reg_write,
                       mem_read:  id_valid & id_mem_read,
                       mem_write: id_valid & id_mem_write};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_ctrl   <= BUBBLE_CTRL;
            ID_EXE_Rs <= '0;
            ID_EXE_Rt <= '0;
            ID_EXE_Rd <= '0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_imm    <= '0;
            alu_q     <= '0;
        end else if (load_bubble) begin
            ex_ctrl <= BUBBLE_CTRL;
        end else begin
            ex_ctrl   <= id_ctrl;
            ID_EXE_Rs <= id_rs;
            ID_EXE_Rt <= id_rt;
            ID_EXE_Rd <= id_rd;
            ex_op1    <= id_op1;
            ex_op2    <= id_op2;
            ex_imm    <= id_imm;
            alu_q     <= id_alu_ctrl;
        end
    end

    assign ex_valid     = ex_ctrl.valid;
    assign ex_reg_write = ex_ctrl.reg_write;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_alu_ctrl  = alu_q;

`ifdef ID_EXE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             stall_count <= '0;
        else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Directed bench for id_exe_stage: reset, load-use stall, r0, flush, ALU
// forwarding case, invalid ID, reset mid-stall and (optionally) stall stats.
module tb_id_exe_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_op1, id_op2, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]  id_alu_ctrl;
    logic        flush;
    logic [4:0]  ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid;
    logic [3:0]  ex_alu_ctrl;
    logic        stall;
`ifdef ID_EXE_STATS_EN
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_exe_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_op1(id_op1), .id_op2(id_op2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alu_ctrl(id_alu_ctrl), .flush(flush),
        .ID_EXE_Rs(ID_EXE_Rs), .ID_EXE_Rt(ID_EXE_Rt), .ID_EXE_Rd(ID_EXE_Rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .stall(stall)
`ifdef ID_EXE_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] imm,
                          input logic rw, input logic mr, input logic mw, input logic [3:0] alu);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_op1 = o1; id_op2 = o2; id_imm = imm;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_ctrl = alu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        set_id(1, 5'd3, 5'd4, 5'd9, 32'h1111, 32'h2222, 32'h3333, 1, 1, 1, 4'h7);
        step();
        n_checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
        end
        n_checks++;
        if ({ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd, ex_op1, ex_op2, ex_imm, ex_alu_ctrl} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd, ex_op1, ex_op2, ex_imm, ex_alu_ctrl});
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        @(negedge clk); rst = 1'b0; #1;
    endtask

    task automatic test_load_use();
        // lw r5 <- ...
        set_id(1, 5'd1, 5'd2, 5'd5, 32'hA0, 32'hB0, 32'h10, 1, 1, 0, 4'h2);
        step();
        n_checks++;
        if ({ex_valid, ex_mem_read, ID_EXE_Rd} !== {1'b1, 1'b1, 5'd5}) begin
            n_fail++; $display("FAIL lu_lw_in_ex: got %h expected %h", {ex_valid, ex_mem_read, ID_EXE_Rd}, {1'b1, 1'b1, 5'd5});
        end
        // add r8 <- r5 + r6
        set_id(1, 5'd5, 5'd6, 5'd8, 32'hC1, 32'hC2, 32'h0, 1, 0, 0, 4'h3);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0000) begin
            n_fail++; $display("FAIL lu_bubble: got %b expected 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
        end
        n_checks++;
        if (dut.state !== BUBBLE) begin n_fail++; $display("FAIL lu_state_bubble: got %0d expected %0d", dut.state, BUBBLE); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_no_restall: got %b expected 0", stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_reg_write, ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd, ex_op1, ex_alu_ctrl} !==
            {1'b1, 1'b1, 5'd5, 5'd6, 5'd8, 32'hC1, 4'h3}) begin
            n_fail++; $display("FAIL lu_add_in_ex: got %h expected %h", {ex_valid, ex_reg_write, ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd, ex_op1, ex_alu_ctrl},
                               {1'b1, 1'b1, 5'd5, 5'd6, 5'd8, 32'hC1, 4'h3});
        end
        n_checks++;
        if (dut.state !== RUN) begin n_fail++; $display("FAIL lu_state_run: got %0d expected %0d", dut.state, RUN); end
    endtask

    task automatic test_rd_zero();
        set_id(1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h4, 1, 1, 0, 4'h2);
        step();
        set_id(1, 5'd0, 5'd3, 5'd4, 32'hDEAD, 32'hBEEF, 32'h0, 1, 0, 0, 4'h1);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b expected 0", stall); end
        step();
        n_checks++;
        if ({ex_valid, ID_EXE_Rs, ID_EXE_Rd, ex_op1, ex_op2} !== {1'b1, 5'd0, 5'd4, 32'hDEAD, 32'hBEEF}) begin
            n_fail++; $display("FAIL r0_capture: got %h expected %h", {ex_valid, ID_EXE_Rs, ID_EXE_Rd, ex_op1, ex_op2}, {1'b1, 5'd0, 5'd4, 32'hDEAD, 32'hBEEF});
        end
    endtask

    task automatic test_flush();
        set_id(1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h8, 1, 1, 0, 4'h2);
        step();
        set_id(1, 5'd5, 5'd6, 5'd9, 32'h5, 32'h6, 32'h0, 1, 0, 1, 4'h3);
        flush = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %b expected 0", stall); end
        step();
        flush = 1'b0;
        n_checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'b0000) begin
            n_fail++; $display("FAIL fl_bubble: got %b expected 0000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
        end
        n_checks++;
        if (dut.state !== RUN) begin n_fail++; $display("FAIL fl_state: got %0d expected %0d", dut.state, RUN); end
    endtask

    task automatic test_alu_fwd();
        set_id(1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 1, 0, 0, 4'h3);
        step();
        set_id(1, 5'd3, 5'd7, 5'd10, 32'h33, 32'h77, 32'h0, 1, 0, 0, 4'h4);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", stall); end
        step();
        n_checks++;
        if ({ex_valid, ID_EXE_Rt, ex_op2, ex_alu_ctrl} !== {1'b1, 5'd7, 32'h77, 4'h4}) begin
            n_fail++; $display("FAIL alu_capture: got %h expected %h", {ex_valid, ID_EXE_Rt, ex_op2, ex_alu_ctrl}, {1'b1, 5'd7, 32'h77, 4'h4});
        end
    endtask

    task automatic test_invalid_id();
        set_id(1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 1, 1, 0, 4'h2);
        step();
        set_id(0, 5'd5, 5'd5, 5'd11, 32'h9, 32'h9, 32'h0, 1, 0, 0, 4'h3);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL inv_stall: got %b expected 0", stall); end
        step();
        n_checks++;
        if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL inv_valid: got %b expected 0", ex_valid); end
    endtask

    task automatic test_rst_mid_stall();
        set_id(1, 5'd1, 5'd2, 5'd12, 32'h55, 32'h66, 32'h77, 1, 1, 1, 4'h2);
        step();
        set_id(1, 5'd12, 5'd3, 5'd13, 32'h1, 32'h2, 32'h3, 1, 0, 0, 4'h3);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL rs_pre_stall: got %b expected 1", stall); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 5'b00000) begin
            n_fail++; $display("FAIL rs_ctrl: got %b expected 00000", {stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write});
        end
        n_checks++;
        if ({ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd, ex_op1, ex_op2, ex_imm, ex_alu_ctrl} !== '0) begin
            n_fail++; $display("FAIL rs_data: got %h expected 0", {ID_EXE_Rs, ID_EXE_Rt, ID_EXE_Rd, ex_op1, ex_op2, ex_imm, ex_alu_ctrl});
        end
        n_checks++;
        if (dut.state !== RUN) begin n_fail++; $display("FAIL rs_state: got %0d expected %0d", dut.state, RUN); end
        @(negedge clk); rst = 1'b0; #1;
    endtask

`ifdef ID_EXE_STATS_EN
    task automatic do_hazard();
        set_id(1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 1, 1, 0, 4'h2);
        step();
        set_id(1, 5'd5, 5'd6, 5'd8, 32'h0, 32'h0, 32'h0, 1, 0, 0, 4'h3);
        step();
        step();
    endtask

    task automatic test_stats();
        rst = 1'b1; #2;
        n_checks++;
        if (stall_count !== 16'd0) begin n_fail++; $display("FAIL st_reset: got %0d expected 0", stall_count); end
        @(negedge clk); rst = 1'b0; #1;
        do_hazard(); do_hazard(); do_hazard();
        n_checks++;
        if (stall_count !== 16'd3) begin n_fail++; $display("FAIL st_count3: got %0d expected 3", stall_count); end
        @(negedge clk);
        dut.stall_count = 16'hFFFF;
        #1;
        do_hazard();
        n_checks++;
        if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL st_saturate: got %h expected ffff", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_flush();
        test_alu_fwd();
        test_invalid_id();
        test_rst_mid_stall();
`ifdef ID_EXE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
